// File: rtl/periph_bus_pkg.sv
// Shared address map, slave index and controller state types for the peripheral bus.
package periph_bus_pkg;

   typedef enum logic [2:0] {
      SL_RAM     = 3'd0,
      SL_UART    = 3'd1,
      SL_TIMER   = 3'd2,
      SL_LED4X4  = 3'd3,
      SL_GPIO    = 3'd4,
      SL_BUTTONS = 3'd5,
      SL_SYNTH   = 3'd6,
      SL_FLASH   = 3'd7
   } slave_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   // RAM owns a 64 KiB page (bits [31:16]), flash a 16 MiB page (bits [31:24]);
   // register peripherals own a 16-byte window matched on bits [31:4].
   localparam logic [15:0] RAM_PAGE    = 16'h0000;
   localparam logic [7:0]  FLASH_PAGE  = 8'h01;
   localparam logic [27:0] UART_WIN    = 28'h000_2000;
   localparam logic [27:0] TIMER_WIN   = 28'h000_3000;
   localparam logic [27:0] LED4X4_WIN  = 28'h000_4000;
   localparam logic [27:0] GPIO_WIN    = 28'h000_5000;
   localparam logic [27:0] BUTTONS_WIN = 28'h000_6000;
   localparam logic [27:0] SYNTH_WIN   = 28'h000_7000;

   function automatic logic reg_window_hit(input logic [31:0] address, input logic [27:0] win);
      return address[31:4] == win;
   endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational address decoder: maps a bus address to a peripheral index plus a hit flag.
// Zero latency; no flow control.
module periph_addr_decode
   import periph_bus_pkg::*;
(
   input  logic [31:0] address,
   output slave_idx_t  idx,
   output logic        hit
);

   always_comb begin
      idx = SL_RAM;
      hit = 1'b1;
      if (address[31:16] == RAM_PAGE)               idx = SL_RAM;
      else if (address[31:24] == FLASH_PAGE)        idx = SL_FLASH;
      else if (reg_window_hit(address, UART_WIN))    idx = SL_UART;
      else if (reg_window_hit(address, TIMER_WIN))   idx = SL_TIMER;
      else if (reg_window_hit(address, LED4X4_WIN))  idx = SL_LED4X4;
      else if (reg_window_hit(address, GPIO_WIN))    idx = SL_GPIO;
      else if (reg_window_hit(address, BUTTONS_WIN)) idx = SL_BUTTONS;
      else if (reg_window_hit(address, SYNTH_WIN))   idx = SL_SYNTH;
      else                                           hit = 1'b0;
   end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Bridges one held-until-ready master request to one-hot peripheral selects; s_sel one cycle after
// request, m_ready one cycle after s_ready; unmapped or stalled (TIMEOUT) accesses answer with m_error.
module periph_bus_ctrl
   import periph_bus_pkg::*;
#(
   parameter int NUM_SLAVES = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           m_address,
   input  logic                  m_read,
   input  logic                  m_write,
   input  logic [3:0]            m_write_mask,
   input  logic [31:0]           m_write_value,
   output logic [31:0]           m_read_value,
   output logic                  m_ready,
   output logic                  m_error,
   output logic [NUM_SLAVES-1:0] s_sel,
   output logic [31:0]           s_address,
   output logic                  s_read,
   output logic [3:0]            s_write_mask,
   output logic [31:0]           s_write_value,
   input  logic [31:0]           s_read_value,
   input  logic [NUM_SLAVES-1:0] s_ready,
   output logic [31:0]           err_address,
   output logic [7:0]            err_count,
   input  logic                  err_clear
);

   localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic                    turn_q;
   logic [CNT_W-1:0]        wait_cnt_q;
   logic [31:0]             rdata_q;
   slave_idx_t              dec_idx;
   logic                    dec_hit;
   logic                    mapped;
   logic                    req_ok;
   logic                    req_bad;
   logic                    accept;
   logic                    sel_rdy;
   logic                    wait_expired;
   logic                    err_entry;
   logic [NUM_SLAVES-1:0]   dec_sel;

   periph_addr_decode u_decode (
      .address (m_address),
      .idx     (dec_idx),
      .hit     (dec_hit)
   );

   always_comb begin
      mapped  = dec_hit && (int'(dec_idx) < NUM_SLAVES);
      dec_sel = '0;
      if (mapped) dec_sel[dec_idx] = 1'b1;
      req_ok  = (m_read ^ m_write) && mapped;
      req_bad = (m_read || m_write) && !req_ok;
   end

   // Only the selected peripheral's ready counts; s_sel is one-hot while in ACCESS.
   assign sel_rdy      = |(s_ready & s_sel);
   assign wait_expired = (wait_cnt_q == CNT_LAST);
   assign accept       = (state_q == ST_IDLE) && !turn_q && req_ok;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!turn_q) begin
               if (req_ok)       state_d = ST_ACCESS;
               else if (req_bad) state_d = ST_ERROR;
            end
         end
         ST_ACCESS: begin
            if (sel_rdy)           state_d = ST_DONE;
            else if (wait_expired) state_d = ST_ERROR;
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ERROR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign err_entry = (state_d == ST_ERROR) && (state_q != ST_ERROR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         turn_q        <= 1'b0;
         wait_cnt_q    <= '0;
         rdata_q       <= '0;
         s_sel         <= '0;
         s_address     <= '0;
         s_read        <= 1'b0;
         s_write_mask  <= '0;
         s_write_value <= '0;
      end else begin
         state_q <= state_d;
         // The master still holds its old request during the response cycle.
         turn_q  <= (state_q == ST_DONE) || (state_q == ST_ERROR);
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  s_sel         <= dec_sel;
                  s_address     <= m_address;
                  s_read        <= m_read;
                  s_write_mask  <= m_write ? m_write_mask : 4'b0000;
                  s_write_value <= m_write ? m_write_value : 32'h0;
                  wait_cnt_q    <= '0;
               end
            end
            ST_ACCESS: begin
               if (sel_rdy) rdata_q    <= s_read_value;
               else         wait_cnt_q <= wait_cnt_q + 1'b1;
               if (sel_rdy || wait_expired) begin
                  s_sel        <= '0;
                  s_read       <= 1'b0;
                  s_write_mask <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_address <= '0;
         err_count   <= '0;
      end else begin
         if (err_entry) err_address <= (state_q == ST_IDLE) ? m_address : s_address;
         if (err_clear)                            err_count <= err_entry ? 8'd1 : 8'd0;
         else if (err_entry && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   assign m_ready      = (state_q == ST_DONE) || (state_q == ST_ERROR);
   assign m_error      = (state_q == ST_ERROR);
   assign m_read_value = (state_q == ST_DONE) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl: decode map, latency, turnaround, timeout, reset abort, fault log.
module tb_periph_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [3:0]  m_write_mask;
   logic [31:0] m_write_value;
   logic [31:0] m_read_value;
   logic        m_ready;
   logic        m_error;
   logic [7:0]  s_sel;
   logic [31:0] s_address;
   logic        s_read;
   logic [3:0]  s_write_mask;
   logic [31:0] s_write_value;
   logic [31:0] s_read_value;
   logic [7:0]  s_ready;
   logic [31:0] err_address;
   logic [7:0]  err_count;
   logic        err_clear;

   int n_checks = 0;
   int n_fail   = 0;

   periph_bus_ctrl #(.NUM_SLAVES(8), .TIMEOUT(255)) dut (
      .clk           (clk),
      .reset         (reset),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_write_mask  (m_write_mask),
      .m_write_value (m_write_value),
      .m_read_value  (m_read_value),
      .m_ready       (m_ready),
      .m_error       (m_error),
      .s_sel         (s_sel),
      .s_address     (s_address),
      .s_read        (s_read),
      .s_write_mask  (s_write_mask),
      .s_write_value (s_write_value),
      .s_read_value  (s_read_value),
      .s_ready       (s_ready),
      .err_address   (err_address),
      .err_count     (err_count),
      .err_clear     (err_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single read from an accepting IDLE; mapped slaves answer on the first ACCESS cycle.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic [7:0] exp_sel);
      m_address = addr;
      m_read    = 1'b1;
      step();
      check({tag, " sel"}, s_sel, exp_sel);
      if (exp_sel != 8'h00) begin
         s_ready      = exp_sel;
         s_read_value = addr ^ 32'h5A5A_5A5A;
         step();
         s_ready      = 8'h00;
         s_read_value = 32'h0;
         check({tag, " err"}, m_error, 0);
         check({tag, " rdata"}, m_read_value, addr ^ 32'h5A5A_5A5A);
      end else begin
         check({tag, " err"}, m_error, 1);
      end
      check({tag, " rdy"}, m_ready, 1);
      m_read = 1'b0;
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int pulses;
      int errs;

      reset = 1'b1;
      m_address = 32'h0; m_read = 1'b0; m_write = 1'b0;
      m_write_mask = 4'h0; m_write_value = 32'h0;
      s_read_value = 32'h0; s_ready = 8'h00; err_clear = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rst s_sel", s_sel, 0);
      check("rst s_read", s_read, 0);
      check("rst s_wmask", s_write_mask, 0);
      check("rst m_ready", m_ready, 0);
      check("rst m_error", m_error, 0);
      check("rst m_rdata", m_read_value, 0);
      check("rst err_count", err_count, 0);
      check("rst err_addr", err_address, 0);
      step(); step();
      reset = 1'b1;
      step(); step();

      // uart read, ready at cycle 3, then gpio write presented during the DONE cycle
      m_address = 32'h0002_0004; m_read = 1'b1;
      check("rd c0 rdy", m_ready, 0);
      step();
      check("rd c1 sel", s_sel, 8'b0000_0010);
      check("rd c1 s_read", s_read, 1);
      check("rd c1 wmask", s_write_mask, 0);
      check("rd c1 addr", s_address, 32'h0002_0004);
      step();
      check("rd c2 sel", s_sel, 8'b0000_0010);
      step();
      check("rd c3 sel", s_sel, 8'b0000_0010);
      check("rd c3 rdy", m_ready, 0);
      s_ready = 8'h02; s_read_value = 32'h41;
      step();
      s_ready = 8'h00; s_read_value = 32'h0;
      check("rd c4 rdy", m_ready, 1);
      check("rd c4 err", m_error, 0);
      check("rd c4 rdata", m_read_value, 32'h41);
      check("rd c4 sel", s_sel, 0);
      m_read = 1'b0; m_write = 1'b1; m_address = 32'h0005_0000;
      m_write_mask = 4'b0011; m_write_value = 32'h1234;
      step();
      check("ta c5 rdy", m_ready, 0);
      check("ta c5 rdata", m_read_value, 0);
      check("ta c5 sel", s_sel, 0);
      step();
      check("ta c6 sel", s_sel, 0);
      step();
      check("wr sel", s_sel, 8'b0001_0000);
      check("wr wmask", s_write_mask, 4'b0011);
      check("wr wval", s_write_value, 32'h1234);
      check("wr s_read", s_read, 0);
      s_ready = 8'b1110_1111;
      step();
      check("wr other rdy sel", s_sel, 8'b0001_0000);
      check("wr other rdy wmask", s_write_mask, 4'b0011);
      check("wr other rdy wval", s_write_value, 32'h1234);
      check("wr other rdy m_rdy", m_ready, 0);
      s_ready = 8'h10;
      step();
      s_ready = 8'h00;
      check("wr done rdy", m_ready, 1);
      check("wr done err", m_error, 0);
      check("wr done sel", s_sel, 0);
      m_write = 1'b0; m_write_mask = 4'h0; m_write_value = 32'h0;
      step();
      check("wr one pulse", m_ready, 0);
      step();

      // unmapped read and read+write collision
      s_read_value = 32'hDEAD_BEEF;
      m_address = 32'h0009_0000; m_read = 1'b1;
      step();
      check("um rdy", m_ready, 1);
      check("um err", m_error, 1);
      check("um rdata", m_read_value, 0);
      check("um sel", s_sel, 0);
      check("um err_addr", err_address, 32'h0009_0000);
      check("um err_count", err_count, 1);
      m_read = 1'b0;
      step();
      check("um after rdy", m_ready, 0);
      check("um after err", m_error, 0);
      step();
      m_address = 32'h0004_0000; m_read = 1'b1; m_write = 1'b1; m_write_mask = 4'hF;
      step();
      check("rw err", m_error, 1);
      check("rw sel", s_sel, 0);
      check("rw err_count", err_count, 2);
      check("rw err_addr", err_address, 32'h0004_0000);
      m_read = 1'b0; m_write = 1'b0; m_write_mask = 4'h0;
      step(); step();
      s_read_value = 32'h0;

      // flash timeout, then ready exactly on the last allowed wait cycle
      m_address = 32'h0110_0000; m_read = 1'b1;
      step();
      check("to c1 sel", s_sel, 8'h80);
      for (int c = 2; c <= 255; c++) step();
      check("to c255 sel", s_sel, 8'h80);
      check("to c255 rdy", m_ready, 0);
      step();
      check("to c256 sel", s_sel, 0);
      check("to c256 rdy", m_ready, 1);
      check("to c256 err", m_error, 1);
      check("to err_count", err_count, 3);
      check("to err_addr", err_address, 32'h0110_0000);
      m_read = 1'b0;
      step(); step();
      m_read = 1'b1;
      step();
      for (int c = 2; c <= 255; c++) step();
      s_ready = 8'h80; s_read_value = 32'hCAFE_F00D;
      step();
      s_ready = 8'h00; s_read_value = 32'h0;
      check("late rdy", m_ready, 1);
      check("late err", m_error, 0);
      check("late rdata", m_read_value, 32'hCAFE_F00D);
      check("late err_count", err_count, 3);
      m_read = 1'b0;
      step(); step();

      // reset during a ram access
      m_address = 32'h0000_0100; m_read = 1'b1;
      step();
      check("ra c1 sel", s_sel, 8'h01);
      step();
      reset = 1'b0;
      #1;
      check("ra rst sel", s_sel, 0);
      check("ra rst s_read", s_read, 0);
      check("ra rst rdy", m_ready, 0);
      check("ra rst err_count", err_count, 0);
      m_read = 1'b0;
      step();
      check("ra in rst rdy", m_ready, 0);
      reset = 1'b1;
      step();
      check("ra post rdy", m_ready, 0);
      check("ra post sel", s_sel, 0);
      m_address = 32'h0000_0010; m_write = 1'b1; m_write_mask = 4'hF; m_write_value = 32'hA5A5;
      step();
      check("ra next sel", s_sel, 8'h01);
      check("ra next wmask", s_write_mask, 4'hF);
      s_ready = 8'h01;
      step();
      s_ready = 8'h00;
      check("ra next rdy", m_ready, 1);
      check("ra next err", m_error, 0);
      m_write = 1'b0; m_write_mask = 4'h0; m_write_value = 32'h0;
      step(); step();

      // address map edges
      xfer("map ram",     32'h0000_FFFC, 8'h01);
      xfer("map uart",    32'h0002_000C, 8'h02);
      xfer("map timer",   32'h0003_0000, 8'h04);
      xfer("map led",     32'h0004_0008, 8'h08);
      xfer("map gpio",    32'h0005_000F, 8'h10);
      xfer("map buttons", 32'h0006_0004, 8'h20);
      xfer("map synth",   32'h0007_0000, 8'h40);
      xfer("map flash",   32'h01FF_FFFC, 8'h80);
      xfer("gap 1xxxx",   32'h0001_0000, 8'h00);
      xfer("gap uart+10", 32'h0002_0010, 8'h00);
      xfer("gap 8xxxx",   32'h0008_0000, 8'h00);
      xfer("gap 02xx",    32'h0200_0000, 8'h00);
      xfer("gap 00ff",    32'h00FF_FFFF, 8'h00);
      check("map err_count", err_count, 5);
      check("map err_addr", err_address, 32'h00FF_FFFF);

      // saturation: a held unmapped request re-faults every third cycle
      m_address = 32'h8000_0000; m_read = 1'b1;
      cyc = 0; pulses = 0; errs = 0;
      while (pulses < 260 && cyc < 2000) begin
         step();
         cyc++;
         if (m_ready) pulses++;
         if (m_error) errs++;
      end
      m_read = 1'b0;
      check("sat last cycle", cyc, 778);
      check("sat err pulses", errs, 260);
      check("sat err_count", err_count, 255);
      step(); step();
      m_address = 32'h0008_0000; m_read = 1'b1; err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("clr+err count", err_count, 1);
      check("clr+err err", m_error, 1);
      check("clr+err addr", err_address, 32'h0008_0000);
      m_read = 1'b0;
      step(); step();
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("clr count", err_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/periph_bus_ctrl.md
PERIPH_BUS_CTRL -- requirements
Module: periph_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of peripheral select lines.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum wait cycles per access before abort.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m_address/m_read/m_write/m_write_mask/m_write_value  input  32/1/1/4/32  common memory bus request, held by master until m_ready.
REQ-006 SHALL have ports m_read_value  output  32, m_ready  output  1, m_error  output  1  response to master.
REQ-007 SHALL have ports s_sel  output  NUM_SLAVES (one-hot), s_address  output  32, s_read  output  1, s_write_mask  output  4, s_write_value  output  32  registered peripheral request.
REQ-008 SHALL have ports s_read_value  input  32 (OR of peripheral outputs), s_ready  input  NUM_SLAVES  per-peripheral ready.
REQ-009 SHALL have ports err_address  output  32, err_count  output  8, err_clear  input  1  fault log.

Function
REQ-010 SHALL decode: 0x0000_xxxx->0 ram; 0x0002_000x->1 uart; 0x0003_000x->2 timer; 0x0004_000x->3 led4x4; 0x0005_000x->4 gpio; 0x0006_000x->5 buttons; 0x0007_000x->6 synth; 0x01xx_xxxx->7 flash; all else unmapped.
REQ-011 SHALL implement FSM IDLE, ACCESS, DONE, ERROR.
REQ-012 IDLE: on (m_read xor m_write) with mapped address SHALL register s_* fields, set s_sel[idx], clear wait counter, go ACCESS.
REQ-013 IDLE: on unmapped address, or m_read and m_write both high, SHALL go ERROR without asserting any s_sel.
REQ-014 ACCESS: s_sel/s_address/s_write_* SHALL remain stable; s_write_mask SHALL be 0 for reads; s_read SHALL equal registered m_read.
REQ-015 ACCESS: when s_ready[idx]=1, SHALL capture s_read_value, drop s_sel, go DONE; s_ready of unselected slaves SHALL be ignored.
REQ-016 ACCESS: wait counter SHALL increment each cycle without s_ready; on reaching TIMEOUT SHALL drop s_sel and go ERROR; s_ready in the same cycle as TIMEOUT SHALL win (DONE).
REQ-017 DONE: m_ready=1, m_error=0, m_read_value=captured value for exactly one cycle, then IDLE.
REQ-018 ERROR: m_ready=1, m_error=1, m_read_value=0 for exactly one cycle, then IDLE; writes SHALL have no side effect.
REQ-019 Latency: request seen in IDLE at cycle 0 -> s_sel at cycle 1; s_ready at cycle k -> m_ready at cycle k+1; unmapped -> m_ready at cycle 1.
REQ-020 IDLE SHALL be held one cycle after DONE/ERROR (turnaround) before accepting a new request.
REQ-021 m_ready and m_read_value SHALL be 0 outside DONE/ERROR.
REQ-022 On each entry to ERROR, err_address SHALL load the faulting address and err_count SHALL increment, saturating at 255.
REQ-023 err_clear SHALL zero err_count next cycle; err_clear coincident with error entry SHALL give err_count=1.

Reset
REQ-024 reset low SHALL immediately force IDLE, s_sel=0, s_read=0, s_write_mask=0, m_ready=0, m_error=0, m_read_value=0, err_count=0, err_address=0, counter=0.
REQ-025 Reset asserted mid-ACCESS SHALL drop s_sel asynchronously; no response SHALL be issued for the aborted access.

Structure
REQ-026 Address map constants, slave index enum and state typedef SHALL live in shared package periph_bus_pkg.
REQ-027 Decoding SHALL be a combinational sub-module periph_addr_decode (address in; index and hit out).

Verification
REQ-028 Read 0x00020004, uart s_ready at cycle 3 with value 0x41 -> s_sel=8'b0000_0010 cycles 1-3, m_ready at cycle 4, m_read_value=0x41, m_error=0.
REQ-029 Write 0x00050000 mask 4'b0011 value 0x1234 -> s_write_mask=4'b0011, s_write_value=0x1234 held until gpio ready; one m_ready pulse.
REQ-030 Read 0x00090000 -> no s_sel, m_ready+m_error at cycle 1, err_address=0x00090000, err_count=1.
REQ-031 Read flash 0x01100000 with s_ready never asserted, TIMEOUT=255 -> s_sel drops after 255 wait cycles, m_error pulse, err_count increments; s_ready exactly at cycle 255 -> normal DONE.
REQ-032 Reset low at cycle 2 of ram access -> s_sel=0 same cycle, no m_ready; after release, next request completes normally.
REQ-033 260 consecutive unmapped accesses then err_clear coincident with a further fault -> err_count saturates at 255, then reads 1.
